// File: rtl/cmp_result_filter_pkg.sv
// Shared comparator codes, filter state encoding and a code legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cmp_result_filter_pkg;

    // One-hot comparator result codes, shared with the comparator itself.
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // A code is legal only if it is exactly one of the three one-hot values.
    function automatic logic is_legal_code(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
    endfunction

endpackage

// File: rtl/cmp_result_filter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count reflects inc/clr on the following cycle.
// Backpressure: none; inc beyond saturation is dropped.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count one), cnt (registered count).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cmp_result_filter.sv
// Debounce filter for the comparator's one-hot result: accepts a code after STABLE_N matching strobes.
// Latency: outputs update on the edge sampling the qualifying strobe (visible next cycle).
// Backpressure: none; every strobe with in_vld high is consumed, idle cycles keep the run.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, beats in_vld),
//        in_vld/Y (sampled code), res/res_vld (filtered result), chg (change pulse),
//        err (sticky illegal-code flag), chg_cnt (saturating change count).
module cmp_result_filter
    import cmp_result_filter_pkg::*;
#(
    parameter int STABLE_N = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [2:0]       Y,
    output logic [2:0]       res,
    output logic             res_vld,
    output logic             chg,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_N);

    state_e     state_q, state_d;
    logic [2:0] cand_q, cand_d;
    logic [3:0] run_q, run_d;
    logic [2:0] res_q, res_d;
    logic       res_vld_q, res_vld_d;
    logic       chg_q, chg_d;
    logic       err_q, err_d;
    logic       lock_entry;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        run_d      = run_q;
        res_d      = res_q;
        res_vld_d  = res_vld_q;
        chg_d      = 1'b0;
        err_d      = err_q;
        lock_entry = 1'b0;

        if (clr) begin
            state_d   = ST_EMPTY;
            cand_d    = '0;
            run_d     = '0;
            res_d     = '0;
            res_vld_d = 1'b0;
            err_d     = 1'b0;
        end else if (in_vld) begin
            if (!is_legal_code(Y)) begin
                // Drop the candidate but keep the last accepted result on display.
                err_d   = 1'b1;
                state_d = ST_EMPTY;
                cand_d  = '0;
                run_d   = '0;
            end else if ((state_q != ST_EMPTY) && (Y == cand_q)) begin
                // Run saturates at STABLE_N; further matches while locked are no-ops.
                if (run_q < STABLE_RUN) begin
                    run_d = run_q + 4'd1;
                    if (run_d == STABLE_RUN) begin
                        lock_entry = 1'b1;
                    end
                end
            end else begin
                cand_d = Y;
                run_d  = 4'd1;
                if (STABLE_RUN == 4'd1) begin
                    lock_entry = 1'b1;
                end else begin
                    state_d = ST_TRACK;
                end
            end

            if (lock_entry) begin
                state_d = ST_LOCKED;
                // A bounce that settles back on the shown value is not a change.
                if (!res_vld_q || (cand_d != res_q)) begin
                    res_d     = cand_d;
                    res_vld_d = 1'b1;
                    chg_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            cand_q    <= '0;
            run_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            chg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            chg_q     <= chg_d;
            err_q     <= err_d;
        end
    end

    // Counting chg_d keeps chg_cnt aligned with the chg pulse.
    sat_counter #(
        .W (CNT_W)
    ) u_chg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (chg_d),
        .cnt   (chg_cnt)
    );

    assign res     = res_q;
    assign res_vld = res_vld_q;
    assign chg     = chg_q;
    assign err     = err_q;

endmodule
